// File: rtl/miniled_pkg.sv
// Shared types, mode encodings and sizing helpers for the MiniLED scan driver.
package miniled_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LATCH,
        DISPLAY,
        GAP
    } state_t;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_FULL   = 2'b01;
    localparam logic [1:0] MODE_BLANK  = 2'b10;

    function automatic int words_per_row(input int n_chips, input int n_ch);
        return n_chips * n_ch;
    endfunction

    function automatic int addr_width(input int n_scan, input int n_chips, input int n_ch);
        int n;
        n = n_scan * n_chips * n_ch;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold the value max_val (at least one).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/miniled_bit_shifter.sv
// Serialises gray words MSB-first with a DCLK of 2*DCLK_DIV cycles per bit and
// requests the next word during the last bit of the current one.
module miniled_bit_shifter
    import miniled_pkg::*;
#(
    parameter int GRAY_W   = 16,
    parameter int DCLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              active,
    input  logic              final_word,
    input  logic [GRAY_W-1:0] din,
    output logic              dclk,
    output logic              sdi_raw,
    output logic              word_last,
    output logic              prefetch_req
);

    localparam int PH_W  = cnt_width(2 * DCLK_DIV - 1);
    localparam int BIT_W = cnt_width(GRAY_W - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * DCLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(DCLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(GRAY_W - 1);

    logic [PH_W-1:0]   phase_q;
    logic [BIT_W-1:0]  bit_q;
    logic [GRAY_W-1:0] sreg_q;
    logic              bit_last;

    assign bit_last     = active && (phase_q == PH_LAST);
    assign word_last    = bit_last && (bit_q == BIT_LAST);
    assign prefetch_req = active && (phase_q == '0) && (bit_q == BIT_LAST) && !final_word;
    assign dclk         = active && (phase_q >= PH_HIGH);
    assign sdi_raw      = sreg_q[GRAY_W-1];

    // The next word is loaded at the word boundary; the data arrives from the
    // prefetch that was issued at the start of this word's last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
        end else if (load) begin
            phase_q <= '0;
            bit_q   <= '0;
            sreg_q  <= din;
        end else if (active) begin
            if (bit_last) begin
                phase_q <= '0;
                if (bit_q == BIT_LAST) begin
                    bit_q  <= '0;
                    sreg_q <= din;
                end else begin
                    bit_q  <= bit_q + BIT_W'(1);
                    sreg_q <= sreg_q << 1;
                end
            end else begin
                phase_q <= phase_q + PH_W'(1);
            end
        end
    end

endmodule

// File: rtl/miniled_scan_driver.sv
// MiniLED panel scan driver: fetches each row from the frame buffer, shifts it
// into the driver chain, latches it and runs the GCLK burst with one row selected.
module miniled_scan_driver
    import miniled_pkg::*;
#(
    parameter int N_CHIPS     = 2,
    parameter int N_CH        = 16,
    parameter int GRAY_W      = 16,
    parameter int N_SCAN      = 4,
    parameter int DCLK_DIV    = 1,
    parameter int LE_CYC      = 2,
    parameter int GCLK_PULSES = 256,
    parameter int GAP_CYC     = 4,
    localparam int W          = words_per_row(N_CHIPS, N_CH),
    localparam int ADDR_W     = addr_width(N_SCAN, N_CHIPS, N_CH)
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_frame_start,
    input  logic [1:0]        I_mode,
    output logic              O_rd_en,
    output logic [ADDR_W-1:0] O_rd_addr,
    input  logic [GRAY_W-1:0] I_rd_data,
    output logic              LE,
    output logic              DCLK,
    output logic              SDI,
    output logic              GCLK,
    output logic [N_SCAN-1:0] O_scan,
    output logic              O_busy,
    output logic              O_frame_done
);

    localparam int CNT_MAX = max_int(max_int(2 * GCLK_PULSES - 1, LE_CYC - 1),
                                     max_int(max_int(GAP_CYC - 1, W - 1), 1));
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int ROW_W   = cnt_width(N_SCAN - 1);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic              rd_pend_q;
    logic [GRAY_W-1:0] next_word_q;

    logic              fetch_rd;
    logic              final_word;
    logic              word_last;
    logic              prefetch_req;
    logic              sdi_raw;
    logic              shift_dclk;
    logic [GRAY_W-1:0] word_in;
    logic              last_row;

    assign fetch_rd   = (state_q == FETCH) && (cnt_q == '0);
    assign final_word = (cnt_q == CNT_W'(W - 1));
    assign last_row   = (row_q == ROW_W'(N_SCAN - 1));
    assign word_in    = rd_pend_q ? I_rd_data : next_word_q;

    miniled_bit_shifter #(
        .GRAY_W   (GRAY_W),
        .DCLK_DIV (DCLK_DIV)
    ) u_shifter (
        .clk          (I_clk),
        .rst          (I_rst),
        .load         ((state_q == FETCH) && (cnt_q == CNT_W'(1))),
        .active       (state_q == SHIFT),
        .final_word   (final_word),
        .din          (word_in),
        .dclk         (shift_dclk),
        .sdi_raw      (sdi_raw),
        .word_last    (word_last),
        .prefetch_req (prefetch_req)
    );

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= MODE_NORMAL;
            pend_q      <= 1'b0;
            addr_hold_q <= '0;
            rd_pend_q   <= 1'b0;
            next_word_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            addr_hold_q <= O_rd_addr;
            rd_pend_q   <= O_rd_en;
            if (rd_pend_q) begin
                next_word_q <= I_rd_data;
            end
        end
    end

    // cnt_q is shared: fetch cycle, word index in SHIFT, LE width, GCLK half
    // periods and gap length. A request in the frame's final cycle chains a frame.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pend_d  = pend_q | (I_frame_start && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (I_frame_start || pend_q) begin
                    state_d = FETCH;
                    row_d   = '0;
                    cnt_d   = '0;
                    mode_d  = I_mode;
                    pend_d  = 1'b0;
                end
            end
            FETCH: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (word_last) begin
                    if (final_word) begin
                        state_d = LATCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LATCH: begin
                if (cnt_q == CNT_W'(LE_CYC - 1)) begin
                    state_d = DISPLAY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DISPLAY: begin
                if (cnt_q == CNT_W'(2 * GCLK_PULSES - 1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (!last_row) begin
                        state_d = FETCH;
                        row_d   = row_q + ROW_W'(1);
                    end else if (pend_q || I_frame_start) begin
                        state_d = FETCH;
                        row_d   = '0;
                        mode_d  = I_mode;
                        pend_d  = pend_q & I_frame_start;
                    end else begin
                        state_d = IDLE;
                        pend_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state so reset clears them at once.
    always_comb begin
        O_rd_en      = fetch_rd || prefetch_req;
        O_rd_addr    = addr_hold_q;
        if (fetch_rd) begin
            O_rd_addr = ADDR_W'(int'(row_q) * W + W - 1);
        end else if (prefetch_req) begin
            O_rd_addr = addr_hold_q - ADDR_W'(1);
        end
        O_busy       = (state_q != IDLE);
        LE           = (state_q == LATCH);
        DCLK         = shift_dclk;
        SDI          = 1'b0;
        if (state_q == SHIFT) begin
            if (mode_q == MODE_FULL) begin
                SDI = 1'b1;
            end else if (mode_q != MODE_BLANK) begin
                SDI = sdi_raw;
            end
        end
        GCLK         = (state_q == DISPLAY) && !cnt_q[0] && (mode_q != MODE_BLANK);
        O_scan       = '0;
        if ((state_q == DISPLAY) && (mode_q != MODE_BLANK)) begin
            O_scan = N_SCAN'(1) << row_q;
        end
        O_frame_done = (state_q == GAP) && (cnt_q == CNT_W'(GAP_CYC - 1)) && last_row;
    end

endmodule

// File: doc/miniled_scan_driver.md
# miniled_scan_driver

Parametrised successor to the fixed four-scan MiniLED panel driver. Reads per-zone gray words from a synchronous frame buffer and serialises them MSB-first to a daisy chain of constant-current driver chips (DCLK/SDI/LE). Then runs a GCLK PWM burst while driving one-hot scan lines. Chip count, channels, gray width, scan count and timing are generic; adds test modes and one-deep frame-request queuing.

## Interface
- N_CHIPS, 2: driver chips in the daisy chain
- N_CH, 16: channels per chip
- GRAY_W, 16: bits per gray word
- N_SCAN, 4: scan lines (rows), ≥1
- DCLK_DIV, 1: DCLK half-period in clk cycles, ≥1
- LE_CYC, 2: LE high width in clk cycles, ≥1
- GCLK_PULSES, 256: GCLK pulses per row display, ≥1
- GAP_CYC, 4: dead time after each row, ≥1
- Derived: W = N_CHIPS*N_CH words/row; ADDR_W = clog2(N_SCAN*W)
- I_clk  in  1  sole clock
- I_rst  in  1  asynchronous, active-high reset
- I_frame_start  in  1  one-cycle frame request
- I_mode  in  2  00 normal, 01 full-on, 10 blank, 11 treated as normal
- O_rd_en  out  1  frame-buffer read strobe
- O_rd_addr  out  ADDR_W  read address
- I_rd_data  in  GRAY_W  read data, valid the cycle after O_rd_en
- LE, DCLK, SDI, GCLK  out  1 each  chip interface
- O_scan  out  N_SCAN  one-hot active-high row select
- O_busy  out  1  frame in progress
- O_frame_done  out  1  one-cycle pulse at end of frame

## Operation
- Reset: all outputs 0, state IDLE, pending flag cleared, row counter 0.
- States: IDLE → FETCH → SHIFT → LATCH → DISPLAY → GAP → (FETCH for next row | IDLE/FETCH after last row).
- IDLE: on I_frame_start, or pending flag set, sample I_mode, set row=0, go to FETCH. O_busy=1 from the next cycle through the last GAP cycle.
- FETCH (2 cycles): O_rd_en with the row's first address, then capture I_rd_data into the shift register.
- Word order within a row: addresses row*W+W-1 down to row*W (the farthest chip is shifted first). Bits MSB first.
- SHIFT: each bit spans 2*DCLK_DIV cycles. DCLK is low for the first DCLK_DIV cycles, with SDI updated in the first of them, then high for DCLK_DIV cycles. The next word is prefetched: O_rd_en is asserted in the first cycle of a word's last bit, and data is loaded at the bit boundary. No read is issued after the row's final word.
- Mode 01: SDI=1 for every bit. Mode 10: SDI=0. Reads are still issued in both modes.
- LATCH: LE=1 for LE_CYC cycles, DCLK=0.
- DISPLAY: O_scan[row]=1. GCLK toggles each cycle, starting high, for GCLK_PULSES pulses (2*GCLK_PULSES cycles). In mode 10, GCLK and O_scan stay 0 for the same duration.
- GAP: O_scan=0, GCLK=0 for GAP_CYC cycles. On the last row's final GAP cycle, O_frame_done=1.
- Request while busy: set the pending flag. Extra requests collapse into it. The pending frame starts in the cycle after O_frame_done (IDLE is skipped, O_busy stays 1).
- Reset mid-frame: everything returns to reset values immediately. No partial LE is ever issued after reset release.

## Timing
- Latency: I_frame_start at cycle t gives O_rd_en at t+1 and the first DCLK rise at t+3+DCLK_DIV.
- Row length: 2 + W*GRAY_W*2*DCLK_DIV + LE_CYC + 2*GCLK_PULSES + GAP_CYC cycles. Frame length is N_SCAN times the row length.
- SDI is stable for DCLK_DIV cycles before and after each DCLK rise.
- LE never overlaps DCLK high. GCLK never overlaps LE. At most one O_scan bit is high.
- O_rd_addr holds its last value when O_rd_en=0.

## Structure
- Package miniled_pkg:
  - state enum (IDLE, FETCH, SHIFT, LATCH, DISPLAY, GAP)
  - mode constants MODE_NORMAL/FULL/BLANK
  - function for W/ADDR_W
- Sub-module miniled_bit_shifter:
  - DCLK phase counter, bit counter, word shift register
  - outputs bit_last/word_last strobes and the prefetch request
- Top-level FSM holds the row, LE, GCLK and gap counters.

## Test plan
Bench parameters: N_CHIPS=2, N_CH=2, GRAY_W=4, N_SCAN=2, DCLK_DIV=1, LE_CYC=2, GCLK_PULSES=8, GAP_CYC=4 (row = 56 cycles, frame = 112).
- Buffer holds addr i = i+1. Pulse start in mode 00 → per row 16 DCLK rises. SDI sequence for row 0 is 0100,0011,0010,0001. O_frame_done exactly 112 cycles after busy rises.
- Mode 01 → all 32 sampled SDI bits are 1. Mode 10 → SDI all 0, GCLK and O_scan never high, frame length still 112.
- Second start pulse at cycle 30 plus a third at 40 → exactly one extra frame, starting the cycle after the first O_frame_done, with O_busy continuously 1.
- Assert I_rst during DISPLAY of row 1 → all outputs 0 in that cycle. After release, the next start begins at row 0 with O_rd_addr=3.
- Over the whole frame, monitors check: LE high exactly 2 cycles per row with DCLK=0, 8 GCLK pulses per row, O_scan one-hot only during DISPLAY, and O_rd_en count = 8 per frame.
